// File: rtl/spike_dispatcher.sv
// spike_dispatcher: buffers {origin, destination} spike packets in a small
// FIFO and delivers each origin to the source-address slice of the addressed
// local mac unit, one delivery per clock, stalling while clear is high.
//
// Handshake: a packet transfers on a rising edge where pkt_valid && pkt_ready;
// pkt_ready depends only on FIFO fullness and reset, never on pkt_valid, and
// a full FIFO refuses pushes even when a pop happens on the same edge.
module spike_dispatcher #(
  parameter int NUM_NEURONS = 10,
  parameter int ADDR_W      = 12,
  parameter int BASE_ADDR   = 0,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          pkt_valid,
  output logic                          pkt_ready,
  input  logic [2*ADDR_W-1:0]           pkt_data,
  output logic [NUM_NEURONS*ADDR_W-1:0] src_addr_out,
  output logic [NUM_NEURONS-1:0]        deliver_strobe,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    dropped_count,
  output logic                          busy,
  output logic [1:0]                    dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [ADDR_W:0] LO_BOUND = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] N_RANGE  = (ADDR_W+1)'(NUM_NEURONS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_e;

  state_e                              state_q, state_d;
  logic [2*ADDR_W-1:0]                 mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]                    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]                    count_q, count_d;
  logic [NUM_NEURONS-1:0][ADDR_W-1:0]  src_q, src_d;
  logic [NUM_NEURONS-1:0]              strobe_q, strobe_d;
  logic [7:0]                          drop_q, drop_d;
  logic                                busy_q;

  logic                                full, empty, push, pop;
  logic [2*ADDR_W-1:0]                 head;
  logic [ADDR_W-1:0]                   head_origin, head_dest;
  logic [ADDR_W:0]                     offset_ext;
  logic                                in_range;

  assign full      = (count_q == LVL_W'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign pkt_ready = !full && !reset;
  assign push      = pkt_valid && pkt_ready;

  // Head-of-FIFO decode; the extra offset bit is a borrow flag that marks
  // destinations below BASE_ADDR.
  assign head        = mem_q[rd_ptr_q];
  assign head_dest   = head[ADDR_W-1:0];
  assign head_origin = head[2*ADDR_W-1:ADDR_W];
  assign offset_ext  = {1'b0, head_dest} - LO_BOUND;
  assign in_range    = !offset_ext[ADDR_W] && (offset_ext < N_RANGE);

  // Next state and pop decision; leaving IDLE or STALL pops on the same edge
  // so an idle dispatcher delivers with one cycle of latency.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          if (clear) state_d = STALL;
          else begin
            pop     = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (clear)      state_d = STALL;
        else if (empty) state_d = IDLE;
        else            pop = 1'b1;
      end
      STALL: begin
        if (!clear) begin
          if (empty) state_d = IDLE;
          else begin
            pop     = 1'b1;
            state_d = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    count_d = count_q + LVL_W'(push) - LVL_W'(pop);
    if (pop && (count_d == '0)) state_d = IDLE;
  end

  // Delivery datapath: route the popped origin to its slice or count a drop.
  always_comb begin
    src_d    = src_q;
    strobe_d = '0;
    drop_d   = drop_q;
    if (pop) begin
      if (in_range) begin
        for (int k = 0; k < NUM_NEURONS; k++) begin
          if (offset_ext[ADDR_W-1:0] == ADDR_W'(k)) begin
            src_d[k]    = head_origin;
            strobe_d[k] = 1'b1;
          end
        end
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  // Packet storage; contents are don't-care until written, so no reset.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= pkt_data;
  end

  // Control state, pointers and registered outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      src_q    <= '1;
      strobe_q <= '0;
      drop_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q  <= count_d;
      src_q    <= src_d;
      strobe_q <= strobe_d;
      drop_q   <= drop_d;
      busy_q   <= (count_d != '0) || (strobe_d != '0);
    end
  end

  assign src_addr_out   = src_q;
  assign deliver_strobe = strobe_q;
  assign fifo_level     = count_q;
  assign dropped_count  = drop_q;
  assign busy           = busy_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_spike_dispatcher.sv
// Self-checking bench for spike_dispatcher: directed vector table, hand-built
// multi-cycle sequences and randomized traffic, all checked against a
// queue-based packet model of the dispatcher.
module tb_spike_dispatcher;

  localparam int N     = 10;
  localparam int AW    = 12;
  localparam int BASE  = 0;
  localparam int DEPTH = 8;

  // ---------------- clock / reset / DUT ----------------
  logic              CLK = 1'b0;
  logic              rst = 1'b1;
  logic              clr = 1'b0;
  logic              vld = 1'b0;
  logic [2*AW-1:0]   dat = '0;
  logic              pkt_ready;
  logic [N*AW-1:0]   src_addr_out;
  logic [N-1:0]      deliver_strobe;
  logic [3:0]        fifo_level;
  logic [7:0]        dropped_count;
  logic              busy;
  logic [1:0]        dbg_state;

  always #5 CLK = ~CLK;

  spike_dispatcher #(
    .NUM_NEURONS(N), .ADDR_W(AW), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .reset(rst), .clear(clr), .pkt_valid(vld), .pkt_ready(pkt_ready),
    .pkt_data(dat), .src_addr_out(src_addr_out), .deliver_strobe(deliver_strobe),
    .fifo_level(fifo_level), .dropped_count(dropped_count), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [2*AW-1:0]       exp_q[$];
  logic [N-1:0][AW-1:0]  m_src;
  logic [N-1:0]          m_strobe;
  int                    m_drop;
  logic                  m_busy;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model over the edge, compare.
  task automatic step(input logic r, input logic c, input logic v, input logic [2*AW-1:0] d);
    logic acc, pp;
    logic [2*AW-1:0] e;
    int dv;
    rst = r; clr = c; vld = v; dat = d;
    #1;
    chk("pkt_ready", pkt_ready, (!r && exp_q.size() < DEPTH));
    acc = v && !r && (exp_q.size() < DEPTH);
    pp  = !r && !c && (exp_q.size() > 0);
    @(posedge CLK);
    m_strobe = '0;
    if (r) begin
      exp_q.delete();
      m_src  = '1;
      m_drop = 0;
    end else begin
      if (pp) begin
        e  = exp_q.pop_front();
        dv = int'(e[AW-1:0]);
        if (dv >= BASE && dv < BASE + N) begin
          m_src[dv-BASE]    = e[2*AW-1:AW];
          m_strobe[dv-BASE] = 1'b1;
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
      if (acc) exp_q.push_back(d);
    end
    m_busy = (exp_q.size() != 0) || (m_strobe != '0);
    #1;
    chk("fifo_level", fifo_level, exp_q.size());
    chk("deliver_strobe", deliver_strobe, m_strobe);
    chk("src_addr_out", src_addr_out, m_src);
    chk("dropped_count", dropped_count, m_drop);
    chk("busy", busy, m_busy);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic            rst, clr, vld;
    logic [2*AW-1:0] data;
    logic [N-1:0]    exp_strobe;
    logic [3:0]      exp_level;
    logic [7:0]      exp_drop;
    logic            exp_busy;
    int              slice;
    logic [AW-1:0]   slice_val;
  } vec_t;

  vec_t tbl[13];
  logic [2*AW-1:0] pk[$];
  int idx;
  logic take;
  logic [AW-1:0] rnd_dest;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 10'h000, 4'd0, 8'd0, 1'b0, -1, 12'h000};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 24'h000003, 10'h000, 4'd1, 8'd0, 1'b1, -1, 12'h000};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 10'h008, 4'd0, 8'd0, 1'b1,  3, 12'h000};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 10'h000, 4'd0, 8'd0, 1'b0, -1, 12'h000};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 24'h0AB00A, 10'h000, 4'd1, 8'd0, 1'b1, -1, 12'h000};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 24'h0CDFFB, 10'h000, 4'd1, 8'd1, 1'b1, -1, 12'h000};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 24'h123009, 10'h000, 4'd1, 8'd2, 1'b1, -1, 12'h000};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 10'h200, 4'd0, 8'd2, 1'b1,  9, 12'h123};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 10'h000, 4'd0, 8'd2, 1'b0, -1, 12'h000};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 24'h055001, 10'h000, 4'd1, 8'd2, 1'b1, -1, 12'h000};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 24'h000000, 10'h000, 4'd1, 8'd2, 1'b1, -1, 12'h000};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 24'h000000, 10'h002, 4'd0, 8'd2, 1'b1,  1, 12'h055};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 24'h000000, 10'h000, 4'd0, 8'd2, 1'b0, -1, 12'h000};

    m_src = '1; m_strobe = '0; m_drop = 0; m_busy = 1'b0;

    // Initial reset, then check reset values including the FSM state.
    step(1'b1, 1'b0, 1'b0, '0);
    chk("reset_src", src_addr_out, {N*AW{1'b1}});
    chk("reset_state", dbg_state, 2'd0);

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].rst, tbl[i].clr, tbl[i].vld, tbl[i].data);
      chk($sformatf("tbl%0d_strobe", i), deliver_strobe, tbl[i].exp_strobe);
      chk($sformatf("tbl%0d_level", i), fifo_level, tbl[i].exp_level);
      chk($sformatf("tbl%0d_drop", i), dropped_count, tbl[i].exp_drop);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
      if (tbl[i].slice >= 0)
        chk($sformatf("tbl%0d_slice", i), src_addr_out[tbl[i].slice*AW +: AW], tbl[i].slice_val);
    end

    // ---- burst and backpressure: 10 packets while clear is held ----
    pk.delete();
    for (int i = 0; i < 10; i++) pk.push_back({12'(12'h100 + i), 12'(i)});
    idx = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      take = (idx < 10) && (exp_q.size() < DEPTH);
      step(1'b0, 1'b1, idx < 10, pk[(idx < 10) ? idx : 0]);
      if (take) idx++;
    end
    chk("burst_level_full", fifo_level, 4'd8);
    chk("burst_ready_low", pkt_ready, 1'b0);
    for (int cyc = 0; cyc < 40 && (idx < 10 || exp_q.size() > 0); cyc++) begin
      take = (idx < 10) && (exp_q.size() < DEPTH);
      step(1'b0, 1'b0, idx < 10, pk[(idx < 10) ? idx : 0]);
      if (take) idx++;
    end
    chk("burst_all_accepted", idx, 10);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("burst_drained_level", fifo_level, 4'd0);

    // ---- clear mid-burst ----
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, {12'(12'h200 + i), 12'(i + 4)});
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, '0);
      chk("clear_no_strobe", deliver_strobe, '0);
    end
    step(1'b0, 1'b0, 1'b0, '0);
    chk("clear_resume3", deliver_strobe, 10'h040);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("clear_resume4", deliver_strobe, 10'h080);
    step(1'b0, 1'b0, 1'b0, '0);

    // ---- reset mid-burst ----
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, {12'(12'h300 + i), 12'(i)});
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    chk("rst_level", fifo_level, 4'd0);
    chk("rst_src", src_addr_out, {N*AW{1'b1}});
    chk("rst_drop", dropped_count, 8'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, '0);
      chk("rst_no_strobe", deliver_strobe, '0);
    end
    step(1'b0, 1'b0, 1'b1, 24'h777005);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("rst_new_strobe", deliver_strobe, 10'h020);
    chk("rst_new_slice", src_addr_out[5*AW +: AW], 12'h777);
    step(1'b0, 1'b0, 1'b0, '0);

    // ---- simultaneous push/pop at level 3 ----
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, {12'(12'h400 + i), 12'(i)});
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b1, {12'(12'h410 + i), 12'((i + 3) % N)});
      chk("simul_level", fifo_level, 4'd3);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, '0);

    // ---- randomized traffic ----
    for (int i = 0; i < 2000; i++) begin
      rnd_dest = ($urandom_range(0, 4) == 0) ? 12'($urandom) : 12'($urandom_range(0, N - 1));
      step(($urandom_range(0, 299) == 0),
           ((i % 60) < 14) ? 1'b1 : ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) != 0),
           {12'($urandom), rnd_dest});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
